// File: rtl/wb_regfile.sv
// Writeback stage of the 64-bit RISC-V pipeline: selects the writeback value, commits it to
// the 32-entry integer register file, serves two bypassed ID reads and keeps a commit trace/count.
module wb_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MEMWB_RegWrite,
    input  logic            MEMWB_MemtoReg,
    input  logic            MEMWB_Jal,
    input  logic [4:0]      MEMWB_RD,
    input  logic [XLEN-1:0] MEMWB_Result,
    input  logic [XLEN-1:0] MEMWB_Read_Data,
    input  logic [XLEN-1:0] MEMWB_adder_out1,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic [XLEN-1:0] wb_data,
    output logic            trace_valid,
    output logic [4:0]      trace_rd,
    output logic [XLEN-1:0] trace_data,
    output logic [31:0]     wb_count
);

    logic            commit_s;
    logic [XLEN-1:0] wb_sel_s;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            trace_valid_q;
    logic            trace_valid_d;
    logic [4:0]      trace_rd_q;
    logic [4:0]      trace_rd_d;
    logic [XLEN-1:0] trace_data_q;
    logic [XLEN-1:0] trace_data_d;
    logic [31:0]     wb_count_q;
    logic [31:0]     wb_count_d;

    // Writeback source select (link beats load beats ALU) and commit qualification
    always_comb begin
        wb_sel_s = MEMWB_Result;
        if (MEMWB_Jal) begin
            wb_sel_s = MEMWB_adder_out1;
        end else if (MEMWB_MemtoReg) begin
            wb_sel_s = MEMWB_Read_Data;
        end else begin
            wb_sel_s = MEMWB_Result;
        end
        commit_s = MEMWB_RegWrite && (MEMWB_RD != 5'd0);
    end

    // ID read ports; x0 check comes first so a bypass match on x0 still reads zero
    always_comb begin
        rd_data1 = {XLEN{1'b0}};
        rd_data2 = {XLEN{1'b0}};
        if (rs1 == 5'd0) begin
            rd_data1 = {XLEN{1'b0}};
        end else if (commit_s && (MEMWB_RD == rs1)) begin
            rd_data1 = wb_sel_s;
        end else begin
            rd_data1 = regs_q[rs1];
        end
        if (rs2 == 5'd0) begin
            rd_data2 = {XLEN{1'b0}};
        end else if (commit_s && (MEMWB_RD == rs2)) begin
            rd_data2 = wb_sel_s;
        end else begin
            rd_data2 = regs_q[rs2];
        end
    end

    // Next state for the array, trace and commit counter
    always_comb begin
        regs_d        = regs_q;
        trace_valid_d = commit_s;
        trace_rd_d    = trace_rd_q;
        trace_data_d  = trace_data_q;
        wb_count_d    = wb_count_q;
        if (commit_s) begin
            regs_d[MEMWB_RD] = wb_sel_s;
            trace_rd_d       = MEMWB_RD;
            trace_data_d     = wb_sel_s;
            wb_count_d       = wb_count_q + 32'd1;
        end else begin
            trace_rd_d   = trace_rd_q;
            trace_data_d = trace_data_q;
            wb_count_d   = wb_count_q;
        end
        regs_d[0] = {XLEN{1'b0}};
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            trace_valid_q <= 1'b0;
            trace_rd_q    <= 5'd0;
            trace_data_q  <= {XLEN{1'b0}};
            wb_count_q    <= 32'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            trace_valid_q <= trace_valid_d;
            trace_rd_q    <= trace_rd_d;
            trace_data_q  <= trace_data_d;
            wb_count_q    <= wb_count_d;
        end
    end

    assign wb_data     = wb_sel_s;
    assign trace_valid = trace_valid_q;
    assign trace_rd    = trace_rd_q;
    assign trace_data  = trace_data_q;
    assign wb_count    = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a behavioural register-file model checked every negedge,
// plus hand-computed literal checks that pin the model.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        we, mtr, jal;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] result, rdata, link;
    logic [63:0] rd_data1, rd_data2, wb_data, trace_data;
    logic        trace_valid;
    logic [4:0]  trace_rd;
    logic [31:0] wb_count;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;
    bit preload_req = 1'b0;

    // model state
    logic [63:0] m_regs [32];
    logic        m_tv;
    logic [4:0]  m_trd;
    logic [63:0] m_tdata;
    logic [31:0] m_count;

    wb_regfile dut (
        .clk(clk), .reset(reset),
        .MEMWB_RegWrite(we), .MEMWB_MemtoReg(mtr), .MEMWB_Jal(jal), .MEMWB_RD(rd),
        .MEMWB_Result(result), .MEMWB_Read_Data(rdata), .MEMWB_adder_out1(link),
        .rs1(rs1), .rs2(rs2), .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_data(wb_data),
        .trace_valid(trace_valid), .trace_rd(trace_rd), .trace_data(trace_data),
        .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_wbval();
        if (jal) return link;
        if (mtr) return rdata;
        return result;
    endfunction

    function automatic logic m_commit();
        return we && (rd != 5'd0);
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] rs);
        if (rs == 5'd0) return 64'd0;
        if (m_commit() && rd == rs) return m_wbval();
        return m_regs[rs];
    endfunction

    // model update at each edge, cleared asynchronously
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            m_tv = 1'b0; m_trd = 5'd0; m_tdata = 64'd0; m_count = 32'd0;
        end else begin
            if (preload_req) m_count = 32'hFFFF_FFFF;
            m_tv = m_commit();
            if (m_commit()) begin
                m_regs[rd] = m_wbval();
                m_trd = rd;
                m_tdata = m_wbval();
                m_count = m_count + 32'd1;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (started && !reset) begin
            check("rd_data1", rd_data1, m_read(rs1));
            check("rd_data2", rd_data2, m_read(rs2));
            check("wb_data", wb_data, m_wbval());
            check("trace_valid", {63'd0, trace_valid}, {63'd0, m_tv});
            check("trace_rd", {59'd0, trace_rd}, {59'd0, m_trd});
            check("trace_data", trace_data, m_tdata);
            if (!preload_req) check("wb_count", {32'd0, wb_count}, {32'd0, m_count});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] r, input logic m, input logic j,
                          input logic [63:0] res, input logic [63:0] rdd, input logic [63:0] lnk);
        we = 1'b1; rd = r; mtr = m; jal = j; result = res; rdata = rdd; link = lnk;
    endtask

    initial begin
        reset = 1'b1;
        we = 1'b0; mtr = 1'b0; jal = 1'b0; rd = 5'd0;
        result = 64'd0; rdata = 64'd0; link = 64'd0; rs1 = 5'd0; rs2 = 5'd0;
        #12 reset = 1'b0;
        started = 1'b1;

        // reset state: every address reads zero on both ports
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            check("reset_rd1", rd_data1, 64'd0);
            check("reset_rd2", rd_data2, 64'd0);
        end
        check("reset_count", {32'd0, wb_count}, 64'd0);
        check("reset_tv", {63'd0, trace_valid}, 64'd0);
        step();

        // ALU commit to x5 with same-cycle bypass
        commit(5'd5, 1'b0, 1'b0, 64'h1234, 64'h0, 64'h0);
        rs1 = 5'd5; rs2 = 5'd0;
        #1;
        check("bypass_rd1", rd_data1, 64'h1234);
        check("bypass_rd2_x0", rd_data2, 64'd0);
        step();
        we = 1'b0; rs2 = 5'd5;
        #1;
        check("x5_tv", {63'd0, trace_valid}, 64'd1);
        check("x5_trd", {59'd0, trace_rd}, 64'd5);
        check("x5_tdata", trace_data, 64'h1234);
        check("x5_count", {32'd0, wb_count}, 64'd1);
        check("x5_rd1", rd_data1, 64'h1234);
        check("x5_rd2_same", rd_data2, 64'h1234);
        step();

        // Jal beats MemtoReg, then load data
        commit(5'd7, 1'b1, 1'b1, 64'h11, 64'hAA, 64'h40);
        rs1 = 5'd7;
        #1;
        check("jal_wb", wb_data, 64'h40);
        check("jal_rd1", rd_data1, 64'h40);
        step();
        jal = 1'b0;
        #1;
        check("load_wb", wb_data, 64'hAA);
        check("jal_tdata", trace_data, 64'h40);
        check("jal_count", {32'd0, wb_count}, 64'd2);
        step();
        we = 1'b0;
        #1;
        check("load_rd1", rd_data1, 64'hAA);
        check("load_count", {32'd0, wb_count}, 64'd3);

        // write to x0 is not a commit
        commit(5'd0, 1'b0, 1'b0, 64'hFFFF, 64'h0, 64'h0);
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        check("x0_rd1_pre", rd_data1, 64'd0);
        check("x0_wb", wb_data, 64'hFFFF);
        step();
        we = 1'b0;
        #1;
        check("x0_rd1_post", rd_data1, 64'd0);
        check("x0_tv", {63'd0, trace_valid}, 64'd0);
        check("x0_count", {32'd0, wb_count}, 64'd3);
        check("x0_trd_hold", {59'd0, trace_rd}, 64'd7);
        step();

        // back-to-back commits to x9, rs2 bypass
        commit(5'd9, 1'b0, 1'b0, 64'h1, 64'h0, 64'h0);
        rs1 = 5'd5; rs2 = 5'd9;
        step();
        result = 64'h2;
        #1;
        check("b2b_bypass_rd2", rd_data2, 64'h2);
        step();
        we = 1'b0;
        #1;
        check("b2b_rd2", rd_data2, 64'h2);
        check("b2b_count", {32'd0, wb_count}, 64'd5);

        // counter wrap
        preload_req = 1'b1;
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        #1;
        check("preload_count", {32'd0, wb_count}, 64'hFFFF_FFFF);
        commit(5'd10, 1'b0, 1'b0, 64'h77, 64'h0, 64'h0);
        step();
        preload_req = 1'b0;
        we = 1'b0;
        #1;
        check("wrap_count", {32'd0, wb_count}, 64'd0);
        step();

        // reset in the middle of a commit
        commit(5'd3, 1'b0, 1'b0, 64'h99, 64'h0, 64'h0);
        rs1 = 5'd3;
        step();
        result = 64'h55;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        we = 1'b0;
        #1;
        check("rst_x3", rd_data1, 64'd0);
        check("rst_tv", {63'd0, trace_valid}, 64'd0);
        check("rst_count", {32'd0, wb_count}, 64'd0);
        step();

        // operation resumes after reset
        commit(5'd31, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0, 64'h0);
        rs1 = 5'd31; rs2 = 5'd3;
        step();
        we = 1'b0;
        #1;
        check("post_rst_rd1", rd_data1, 64'hDEAD_BEEF_0000_0001);
        check("post_rst_count", {32'd0, wb_count}, 64'd1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage register file for the 64-bit pipelined RISC-V core; it consumes the MEM/WB pipeline register outputs. It selects the writeback value from the ALU result, load data, or link address, and commits it to the 32-entry integer register file. It serves the ID stage's two read ports with same-cycle write-through bypass, and provides a registered commit trace and a commit counter for the bench and debug.

## Interface
- XLEN, 64, datapath width
- NREG, 32, number of architectural registers (index width fixed at 5)
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- MEMWB_RegWrite  in  1  write enable from MEM/WB
- MEMWB_MemtoReg  in  1  select load data
- MEMWB_Jal  in  1  select link address
- MEMWB_RD  in  5  destination register
- MEMWB_Result  in  XLEN  ALU result
- MEMWB_Read_Data  in  XLEN  load data
- MEMWB_adder_out1  in  XLEN  PC+4 link value
- rs1, rs2  in  5  ID-stage read addresses
- rd_data1, rd_data2  out  XLEN  read data (combinational)
- wb_data  out  XLEN  selected writeback value (combinational, feeds EX forwarding)
- trace_valid  out  1  registered pulse: a commit happened last cycle
- trace_rd  out  5  register committed
- trace_data  out  XLEN  value committed
- wb_count  out  32  number of effective commits since reset

## Operation
- Writeback mux priority: MEMWB_Jal → adder_out1; else MEMWB_MemtoReg → Read_Data; else Result. Both selects high: Jal wins.
- Effective commit: MEMWB_RegWrite=1 and MEMWB_RD≠0. Only effective commits write the array, update the trace, or count.
- x0 is hardwired to zero. It is never written, and reads of x0 return 0 even when bypass conditions match.
- Read port n: if rsn≠0 and an effective commit targets rsn this cycle, return wb_data (bypass). Else if rsn=0, return 0. Else return the array entry.
- rs1=rs2 is legal. Both ports return identical data.
- Trace registers load on every clock. trace_valid takes the effective-commit flag. trace_rd and trace_data load only when the commit is effective and otherwise hold.
- wb_count increments by 1 per effective commit and wraps from 0xFFFFFFFF to 0.
- Reset clears all 32 entries, the trace registers and wb_count to 0.

## Timing
- Array write, trace update and count update occur at posedge clk.
- Read paths are combinational. Bypass makes a value committed at edge N visible at the ID read during the cycle before edge N (same-cycle write/read).
- Trace latency: 1 cycle after commit, i.e. trace_valid is high for the cycle following the edge at which the array was written.
- Reset is asynchronous. Assertion mid-operation clears state immediately, and any commit presented during reset is dropped (no write, no trace, no count).
- After reset: rd_data1/2=0 for all addresses, trace_valid=0, trace_rd=0, trace_data=0, wb_count=0. wb_data stays combinational from its inputs.
- Back-to-back commits to the same rd: the later commit wins and the array holds the last value. The count increments each cycle.

## Test plan
- Reset then read all 32 addresses on both ports → every read returns 0; wb_count=0; trace_valid=0.
- Commit RegWrite=1, RD=5, MemtoReg=0, Jal=0, Result=0x1234 with rs1=5 in the same cycle → rd_data1=0x1234 before the edge (bypass). After the edge the array holds it, trace_valid=1, trace_rd=5, trace_data=0x1234, wb_count=1.
- Commit RD=7 with MemtoReg=1, Jal=1, Read_Data=0xAA, adder_out1=0x40 → x7=0x40 (Jal priority). Then MemtoReg=1, Jal=0 → x7=0xAA.
- Commit RegWrite=1, RD=0, Result=0xFFFF with rs1=rs2=0 → reads 0 before and after the edge; trace_valid=0; wb_count unchanged.
- Preload wb_count to 0xFFFFFFFF via 2^32−1 commits (or force), then one more commit → wb_count=0.
- Write x3=0x99, assert reset mid-cycle while a commit to x3=0x55 is presented → x3 reads 0, trace_valid=0 and wb_count=0 after reset release.
